// File: rtl/framebuffer_oled_scanout.sv
// Framebuffer read client: scans the frame in SSD1306 page order and streams bit-reversed column bytes.
// Define FB_SCANOUT_CONTINUOUS_EN for free-running refresh instead of one frame per start.
module framebuffer_oled_scanout #(
    parameter int H_PIXELS       = 128,
    parameter int V_PIXELS       = 64,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       frame_done,
    output logic       error,
    output logic       fb_re,
    output logic [7:0] fb_r_xpos,
    output logic [7:0] fb_r_ypos,
    output logic       fb_r_mode,
    input  logic       fb_r_data_valid,
    input  logic [7:0] fb_dout,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last
);
    localparam int PAGES = V_PIXELS / 8;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_OUT, S_ADV} state_t;

    state_t        state_q, state_d;
    logic [7:0]    col_q, col_d;
    logic [4:0]    page_q, page_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          error_q, error_d;
    logic          fb_re_q, fb_re_d;
    logic [7:0]    m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          m_last_q, m_last_d;
    logic [7:0]    dout_rev;
    logic          last_col, last_page;

    // Framebuffer bit7 is the top row of the page; the display wants it in bit0.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rev
            assign dout_rev[gi] = fb_dout[7-gi];
        end
    endgenerate

    assign last_col  = (col_q == 8'(H_PIXELS - 1));
    assign last_page = (page_q == 5'(PAGES - 1));

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        page_d       = page_q;
        tmo_d        = tmo_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        error_d      = error_q;
        fb_re_d      = fb_re_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    col_d   = 8'd0;
                    page_d  = 5'd0;
                    tmo_d   = '0;
                    fb_re_d = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (fb_r_data_valid) begin
                    m_data_d  = dout_rev;
                    fb_re_d   = 1'b0;
                    m_valid_d = 1'b1;
                    m_last_d  = last_col && last_page;
                    state_d   = S_OUT;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    fb_re_d = 1'b0;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    state_d   = S_ADV;
                end
            end
            S_ADV: begin
                tmo_d   = '0;
                fb_re_d = 1'b1;
                state_d = S_REQ;
                if (!last_col) begin
                    col_d = col_q + 8'd1;
                end else begin
                    col_d = 8'd0;
                    if (!last_page) begin
                        page_d = page_q + 5'd1;
                    end else begin
                        page_d       = 5'd0;
                        frame_done_d = 1'b1;
`ifndef FB_SCANOUT_CONTINUOUS_EN
                        fb_re_d = 1'b0;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            col_q        <= 8'd0;
            page_q       <= 5'd0;
            tmo_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
            fb_re_q      <= 1'b0;
            m_data_q     <= 8'd0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            page_q       <= page_d;
            tmo_q        <= tmo_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            error_q      <= error_d;
            fb_re_q      <= fb_re_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
        end
    end

    // Address outputs come straight from the counters, which only move in ADV (fb_re low).
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign error      = error_q;
    assign fb_re      = fb_re_q;
    assign fb_r_xpos  = col_q;
    assign fb_r_ypos  = {page_q, 3'b000};
    assign fb_r_mode  = 1'b1;
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
endmodule

// File: tb/tb_framebuffer_oled_scanout.sv
// Bench for framebuffer_oled_scanout: framebuffer responder model, byte-order scoreboard, directed scenarios.
// Define FB_SCANOUT_CONTINUOUS_EN to exercise the free-running refresh build.
module tb_framebuffer_oled_scanout;
    localparam int H     = 128;
    localparam int V     = 64;
    localparam int FRAME = H * V / 8;

    logic       clk = 1'b0;
    logic       rst, start, fb_r_data_valid, m_ready;
    logic [7:0] fb_dout;
    logic       busy, frame_done, error, fb_re, fb_r_mode, m_valid, m_last;
    logic [7:0] fb_r_xpos, fb_r_ypos, m_data;

    framebuffer_oled_scanout dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
        .error(error), .fb_re(fb_re), .fb_r_xpos(fb_r_xpos), .fb_r_ypos(fb_r_ypos),
        .fb_r_mode(fb_r_mode), .fb_r_data_valid(fb_r_data_valid), .fb_dout(fb_dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int pat_mode = 0;
    int fb_en = 1, fb_lat_rand = 0, cur_lat = 2, lat_cnt = 0;
    int ready_rand = 0;
    logic ready_const = 1'b1;
    int exp_idx = 0, fd_count = 0, valid_seen = 0;

    function automatic logic [7:0] pattern(input int col, input int page);
        if (pat_mode == 0) return (col == 0) ? 8'h80 : 8'h00;
        return 8'((col * 7 + page * 29 + 53) & 255);
    endfunction

    function automatic logic [7:0] bitrev(input logic [7:0] b);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = b[7-k];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: wait bound expired, got no event expected event", name);
    endtask

    // Framebuffer responder: answers each read after a few cycles with the pattern byte.
    always begin
        @(negedge clk);
        if (rst || !fb_re) begin
            lat_cnt = 0;
            fb_r_data_valid = 1'b0;
            cur_lat = fb_lat_rand ? $urandom_range(1, 5) : 2;
        end else if (fb_r_data_valid) begin
            fb_r_data_valid = 1'b0;
        end else if (fb_en != 0) begin
            lat_cnt++;
            if (lat_cnt >= cur_lat) begin
                fb_r_data_valid = 1'b1;
                fb_dout = pattern(int'(fb_r_xpos), int'(fb_r_ypos) / 8);
            end
        end
    end

    always begin
        @(negedge clk);
        m_ready = (ready_rand != 0) ? ($urandom_range(0, 99) >= 30) : ready_const;
    end

    // Scoreboard: every accepted byte must be the next one of the page-ordered frame.
    logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0, prev_re = 1'b0;
    logic [7:0] prev_data = 8'd0, prev_x = 8'd0, prev_y = 8'd0;
    always begin
        int rel;
        @(negedge clk);
        #1;
        if (rst) begin
            prev_valid = 1'b0;
            prev_re    = 1'b0;
        end else begin
            if (m_valid) begin
                valid_seen++;
                check("no_re_while_valid", {31'd0, fb_re}, 32'd0);
            end
            if (prev_valid && !prev_ready) begin
                check("stall_valid", {31'd0, m_valid}, 32'd1);
                check("stall_data", {24'd0, m_data}, {24'd0, prev_data});
                check("stall_last", {31'd0, m_last}, {31'd0, prev_last});
            end
            if (prev_re && fb_re) begin
                check("xpos_stable", {24'd0, fb_r_xpos}, {24'd0, prev_x});
                check("ypos_stable", {24'd0, fb_r_ypos}, {24'd0, prev_y});
            end
            if (m_valid && m_ready) begin
                rel = exp_idx % FRAME;
                check("m_data", {24'd0, m_data}, {24'd0, bitrev(pattern(rel % H, rel / H))});
                check("m_last", {31'd0, m_last}, (rel == FRAME - 1) ? 32'd1 : 32'd0);
                if (pat_mode == 0 && rel == 0) check("first_byte_literal", {24'd0, m_data}, 32'h01);
                if (pat_mode == 0 && rel == H) check("page1_byte_literal", {24'd0, m_data}, 32'h01);
                exp_idx++;
            end
            if (frame_done) begin
                check("frame_done_pos", (exp_idx > 0 && exp_idx % FRAME == 0) ? 32'd1 : 32'd0, 32'd1);
`ifdef FB_SCANOUT_CONTINUOUS_EN
                check("busy_at_done", {31'd0, busy}, 32'd1);
`else
                check("busy_at_done", {31'd0, busy}, 32'd0);
`endif
                fd_count++;
                $display("frame %0d done: %0d bytes streamed", fd_count, exp_idx);
            end
            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_last  = m_last;
            prev_data  = m_data;
            prev_re    = fb_re;
            prev_x     = fb_r_xpos;
            prev_y     = fb_r_ypos;
        end
    end

    task automatic pulse_start(input bit expect_accept);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        if (expect_accept) begin
            check("start_busy", {31'd0, busy}, 32'd1);
            check("start_re", {31'd0, fb_re}, 32'd1);
            check("start_xpos", {24'd0, fb_r_xpos}, 32'd0);
            check("start_ypos", {24'd0, fb_r_ypos}, 32'd0);
            check("start_err_clr", {31'd0, error}, 32'd0);
        end
    endtask

    task automatic wait_frames(input int target, input string name);
        int n = 0;
        while (fd_count < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (fd_count < target) fail_now(name);
    endtask

    task automatic wait_bytes(input int target, input string name);
        int n = 0;
        while (exp_idx < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (exp_idx < target) fail_now(name);
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_fb_re"}, {31'd0, fb_re}, 32'd0);
        check({tag, "_xpos"}, {24'd0, fb_r_xpos}, 32'd0);
        check({tag, "_ypos"}, {24'd0, fb_r_ypos}, 32'd0);
        check({tag, "_mode"}, {31'd0, fb_r_mode}, 32'd1);
        check({tag, "_m_data"}, {24'd0, m_data}, 32'd0);
        check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
        check({tag, "_m_last"}, {31'd0, m_last}, 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_reset("rst_mid");
        exp_idx = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_timeout();
        int hi = 0, vs;
        fb_en = 0;
        exp_idx = 0;
        vs = valid_seen;
        pulse_start(1'b1);
        while (fb_re && hi < 100) begin
            hi++;
            @(negedge clk);
            #1;
        end
        check("timeout_re_cycles", hi, 32);
        check("timeout_error", {31'd0, error}, 32'd1);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        check("timeout_no_valid", valid_seen - vs, 0);
        $display("timeout scan: fb_re high %0d cycles, error=%0b", hi, error);
        fb_en = 1;
        pulse_start(1'b1);
        wait_frames(fd_count + 1, "timeout_restart_frame");
`ifdef FB_SCANOUT_CONTINUOUS_EN
        apply_reset();
`endif
    endtask

    initial begin
        int fd0, busy_low;
        rst = 1'b1;
        start = 1'b0;
        fb_r_data_valid = 1'b0;
        fb_dout = 8'd0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_reset("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifdef FB_SCANOUT_CONTINUOUS_EN
        pat_mode = 1;
        fb_lat_rand = 1;
        ready_rand = 1;
        exp_idx = 0;
        fd0 = fd_count;
        busy_low = 0;
        pulse_start(1'b1);
        for (int n = 0; n < 60000 && fd_count < fd0 + 3; n++) begin
            @(negedge clk);
            #1;
            if (!busy) busy_low++;
        end
        if (fd_count < fd0 + 3) fail_now("continuous_frames");
        check("cont_frames", fd_count - fd0, 3);
        check("cont_busy_held", busy_low, 0);
        check("cont_bytes", exp_idx, 3 * FRAME);
        ready_rand = 0;
        fb_lat_rand = 0;
        apply_reset();
        test_timeout();
`else
        // Column-0-only image, always ready.
        pat_mode = 0;
        exp_idx = 0;
        fd0 = fd_count;
        pulse_start(1'b1);
        wait_frames(fd0 + 1, "t1_frame");
        @(negedge clk);
        #1;
        check("t1_bytes", exp_idx, FRAME);
        check("t1_frames", fd_count - fd0, 1);
        check("t1_busy_after", {31'd0, busy}, 32'd0);

        // Backpressure and jittered read latency.
        pat_mode = 1;
        ready_rand = 1;
        fb_lat_rand = 1;
        exp_idx = 0;
        fd0 = fd_count;
        pulse_start(1'b1);
        wait_frames(fd0 + 1, "t2_frame");
        @(negedge clk);
        #1;
        check("t2_bytes", exp_idx, FRAME);
        ready_rand = 0;
        fb_lat_rand = 0;

        // Reset in the middle of a frame, then a clean restart.
        exp_idx = 0;
        pulse_start(1'b1);
        wait_bytes(300, "t4_byte300");
        fd0 = fd_count;
        apply_reset();
        repeat (4) @(negedge clk);
        #1;
        check("t4_no_done", fd_count - fd0, 0);
        check("t4_idle_busy", {31'd0, busy}, 32'd0);
        pulse_start(1'b1);
        wait_frames(fd0 + 1, "t4_frame");
        @(negedge clk);
        #1;
        check("t4_bytes", exp_idx, FRAME);

        // Start while busy must not disturb the frame.
        exp_idx = 0;
        fd0 = fd_count;
        pulse_start(1'b1);
        wait_bytes(10, "t5_byte10");
        pulse_start(1'b0);
        wait_frames(fd0 + 1, "t5_frame");
        repeat (50) @(negedge clk);
        #1;
        check("t5_bytes", exp_idx, FRAME);
        check("t5_frames", fd_count - fd0, 1);
        check("t5_idle_busy", {31'd0, busy}, 32'd0);
        check("t5_idle_re", {31'd0, fb_re}, 32'd0);

        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
